// File: rtl/scaler_chain_param.sv
`default_nettype none
// scaler_chain_param: STAGES-bit binary scaler with per-stage edge pulses, wrap pulse and windowed channel reads.
// Define SCALER_SNAPSHOT_EN to make a rd_lo-then-rd_hi pair coherent across a carry.
module scaler_chain_param #(
  parameter int STAGES  = 33,
  parameter int CHW     = 14,
  parameter int LO_BASE = 5
) (
  input  logic              CLOCK,
  input  logic              rst,
  input  logic              tick,
  input  logic              test_adv,
  input  logic              ld,
  input  logic [STAGES-1:0] ld_val,
  input  logic              rd_lo,
  input  logic              rd_hi,
  output logic [STAGES-1:0] stage,
  output logic [STAGES-1:0] rise,
  output logic [STAGES-1:0] fall,
  output logic              wrap,
  output logic [CHW-1:0]    chan,
  output logic              chan_valid
);

  localparam int HI_BASE = LO_BASE + CHW;

  // Both windows must fit inside the scaler.
  if (LO_BASE < 1 || HI_BASE + CHW - 1 > STAGES) begin : g_bad_window
    $error("scaler_chain_param: LO_BASE+2*CHW-1 exceeds STAGES");
  end

  logic              adv;
  logic [STAGES-1:0] inc;
  logic [CHW-1:0]    lo_win;
  logic [CHW-1:0]    hi_win;
  logic [CHW-1:0]    hi_rd;

  assign adv    = tick | test_adv;
  assign inc    = stage + STAGES'(1);
  assign lo_win = stage[LO_BASE-1 +: CHW];
  assign hi_win = stage[HI_BASE-1 +: CHW];

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      stage <= '0;
      rise  <= '0;
      fall  <= '0;
      wrap  <= 1'b0;
    end else begin
      rise <= '0;
      fall <= '0;
      wrap <= 1'b0;
      if (ld) begin
        stage <= ld_val;
      end else if (adv) begin
        stage <= inc;
        rise  <= inc & ~stage;
        fall  <= ~inc & stage;
        wrap  <= &stage;
      end
    end
  end

`ifdef SCALER_SNAPSHOT_EN
  logic [CHW-1:0] snap;
  logic           snap_v;

  // A load makes any captured high window stale, so it wins over rd_lo.
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      snap   <= '0;
      snap_v <= 1'b0;
    end else begin
      if (rd_lo) begin
        snap   <= hi_win;
        snap_v <= 1'b1;
      end else if (rd_hi) begin
        snap_v <= 1'b0;
      end
      if (ld) begin
        snap_v <= 1'b0;
      end
    end
  end

  assign hi_rd = snap_v ? snap : hi_win;
`else
  assign hi_rd = hi_win;
`endif

  // rd_lo wins a simultaneous request; the losing rd_hi is dropped, not queued.
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      chan       <= '0;
      chan_valid <= 1'b0;
    end else begin
      chan_valid <= rd_lo | rd_hi;
      if (rd_lo) begin
        chan <= lo_win;
      end else if (rd_hi) begin
        chan <= hi_rd;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scaler_chain_param.sv
`default_nettype none
// tb_scaler_chain_param: directed and randomized checks of scaler_chain_param against an arithmetic reference model.
module tb_scaler_chain_param;

  localparam int S  = 33;
  localparam int CW = 14;
  localparam int LB = 5;

  logic          CLOCK = 1'b0;
  logic          rst = 1'b0, tick = 1'b0, test_adv = 1'b0, ld = 1'b0, rd_lo = 1'b0, rd_hi = 1'b0;
  logic [S-1:0]  ld_val = '0;
  logic [S-1:0]  stage, rise, fall;
  logic          wrap, chan_valid;
  logic [CW-1:0] chan;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state and expected outputs.
  logic [S-1:0]  m_cnt = '0;
  logic [CW-1:0] m_chan = '0, m_snap = '0;
  bit            m_snap_v = 1'b0;
  logic [S-1:0]  e_rise = '0, e_fall = '0;
  bit            e_wrap = 1'b0, e_cv = 1'b0;

  scaler_chain_param #(.STAGES(S), .CHW(CW), .LO_BASE(LB)) dut (
    .CLOCK(CLOCK), .rst(rst), .tick(tick), .test_adv(test_adv), .ld(ld), .ld_val(ld_val),
    .rd_lo(rd_lo), .rd_hi(rd_hi), .stage(stage), .rise(rise), .fall(fall), .wrap(wrap),
    .chan(chan), .chan_valid(chan_valid)
  );

  always #5 CLOCK = ~CLOCK;

  // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
  task automatic cyc(input bit r, input bit t, input bit ta, input bit l, input logic [S-1:0] lv,
                     input bit rl, input bit rh);
    logic [S-1:0]  old_v, new_v;
    logic [CW-1:0] lo_w, hi_w;
    bit            pulses;
    rst = r; tick = t; test_adv = ta; ld = l; ld_val = lv; rd_lo = rl; rd_hi = rh;
    old_v = m_cnt;
    lo_w  = CW'(old_v >> (LB - 1));
    hi_w  = CW'(old_v >> (LB + CW - 1));
    if (r) begin
      m_cnt = '0; m_chan = '0; m_snap = '0; m_snap_v = 0;
      e_rise = '0; e_fall = '0; e_wrap = 0; e_cv = 0;
    end else begin
      new_v  = l ? lv : ((t || ta) ? old_v + 1'b1 : old_v);
      pulses = !l && (t || ta);
      e_rise = pulses ? (new_v & ~old_v) : '0;
      e_fall = pulses ? (~new_v & old_v) : '0;
      e_wrap = pulses && (new_v == '0);
      m_cnt  = new_v;
      e_cv   = rl || rh;
      if (rl) begin
        m_chan = lo_w; m_snap = hi_w; m_snap_v = 1;
      end else if (rh) begin
`ifdef SCALER_SNAPSHOT_EN
        m_chan = m_snap_v ? m_snap : hi_w;
`else
        m_chan = hi_w;
`endif
        m_snap_v = 0;
      end
      if (l) m_snap_v = 0;
    end
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic test_reset();
    cyc(1, 1, 1, 0, '0, 1, 1);
    n_tests++; if (stage !== '0) begin n_fail++; $display("FAIL reset_stage got %h want 0", stage); end
    n_tests++; if ({rise, fall, wrap} !== '0) begin n_fail++; $display("FAIL reset_pulses got %h/%h/%b want 0", rise, fall, wrap); end
    n_tests++; if ({chan, chan_valid} !== '0) begin n_fail++; $display("FAIL reset_chan got %h/%b want 0/0", chan, chan_valid); end
    idle();
  endtask

  task automatic test_ticks();
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 1, 0, 0, '0, 0, 0);
      n_tests++;
      if (rise[0] !== (k % 2 == 1) || fall[0] !== (k % 2 == 0) || rise[1] !== (k == 2) ||
          rise[2] !== (k == 4) || wrap !== 1'b0) begin
        n_fail++; $display("FAIL tick%0d_pulses got rise %h fall %h wrap %b", k, rise, fall, wrap);
      end
      n_tests++; if (rise !== e_rise || fall !== e_fall) begin n_fail++; $display("FAIL tick%0d_model got %h/%h want %h/%h", k, rise, fall, e_rise, e_fall); end
      idle();
      n_tests++; if ({rise, fall, wrap} !== '0) begin n_fail++; $display("FAIL tick%0d_pulse_len got %h/%h/%b want 0", k, rise, fall, wrap); end
      idle();
    end
    n_tests++; if (stage !== 33'd5) begin n_fail++; $display("FAIL ticks_final got %0d want 5", stage); end
  endtask

  task automatic test_wrap();
    cyc(0, 1, 0, 1, {S{1'b1}} - 1'b1, 0, 0);
    n_tests++; if ({rise, fall, wrap} !== '0) begin n_fail++; $display("FAIL load_no_pulse got %h/%h/%b want 0", rise, fall, wrap); end
    cyc(0, 1, 0, 0, '0, 0, 0);
    n_tests++; if (stage !== {S{1'b1}} || wrap !== 1'b0) begin n_fail++; $display("FAIL prewrap got %h/%b want all-ones/0", stage, wrap); end
    cyc(0, 1, 0, 0, '0, 0, 0);
    n_tests++; if (stage !== '0 || wrap !== 1'b1) begin n_fail++; $display("FAIL wrap got %h/%b want 0/1", stage, wrap); end
    n_tests++; if (fall !== {S{1'b1}} || rise !== '0) begin n_fail++; $display("FAIL wrap_edges got fall %h rise %h want all-ones/0", fall, rise); end
    idle();
    n_tests++; if ({wrap, fall} !== '0) begin n_fail++; $display("FAIL wrap_len got %b/%h want 0", wrap, fall); end
  endtask

  task automatic test_adv_merge();
    cyc(0, 0, 0, 1, '0, 0, 0);
    cyc(0, 1, 1, 0, '0, 0, 0);
    n_tests++; if (stage !== 33'd1) begin n_fail++; $display("FAIL dual_adv got %0d want 1", stage); end
    cyc(0, 0, 0, 1, '0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, '0, 0, 0);
    n_tests++; if (stage !== 33'd8) begin n_fail++; $display("FAIL test_adv8 got %0d want 8", stage); end
    idle();
  endtask

  task automatic test_read();
    cyc(0, 0, 0, 1, 33'h0_0003_FFF0, 0, 0);
    cyc(0, 0, 0, 0, '0, 1, 0);
    n_tests++; if (chan !== 14'h3FFF || chan_valid !== 1'b1) begin n_fail++; $display("FAIL rd_lo got %h/%b want 3fff/1", chan, chan_valid); end
    idle();
    n_tests++; if (chan !== 14'h3FFF || chan_valid !== 1'b0) begin n_fail++; $display("FAIL rd_hold got %h/%b want 3fff/0", chan, chan_valid); end
    cyc(0, 0, 0, 0, '0, 1, 1);
    n_tests++; if (chan !== 14'h3FFF || chan_valid !== 1'b1) begin n_fail++; $display("FAIL rd_both got %h/%b want 3fff/1", chan, chan_valid); end
    idle();
    n_tests++; if (chan_valid !== 1'b0) begin n_fail++; $display("FAIL rd_both_single got valid %b want 0", chan_valid); end
  endtask

  task automatic test_coherent();
    logic [CW-1:0] want_hi;
`ifdef SCALER_SNAPSHOT_EN
    want_hi = 14'h0005;
`else
    want_hi = 14'h0006;
`endif
    cyc(0, 0, 0, 1, (33'd5 << (LB + CW - 1)) | 33'h3FFFF, 0, 0);
    cyc(0, 1, 0, 0, '0, 1, 0);
    n_tests++; if (chan !== 14'h3FFF || chan_valid !== 1'b1) begin n_fail++; $display("FAIL coh_lo got %h/%b want 3fff/1", chan, chan_valid); end
    idle();
    cyc(0, 0, 0, 0, '0, 0, 1);
    n_tests++; if (chan !== want_hi || chan_valid !== 1'b1) begin n_fail++; $display("FAIL coh_hi got %h/%b want %h/1", chan, chan_valid, want_hi); end
    cyc(0, 0, 0, 0, '0, 0, 1);
    n_tests++; if (chan !== 14'h0006) begin n_fail++; $display("FAIL coh_live got %h want 0006", chan); end
  endtask

  task automatic test_reset_mid();
    cyc(0, 1, 0, 0, '0, 0, 1);
    n_tests++; if (chan_valid !== 1'b1) begin n_fail++; $display("FAIL pre_rst_read got valid %b want 1", chan_valid); end
    cyc(1, 1, 0, 0, '0, 0, 0);
    n_tests++; if ({stage, chan, chan_valid} !== '0) begin n_fail++; $display("FAIL rst_mid got stage %h chan %h valid %b want 0", stage, chan, chan_valid); end
    n_tests++; if ({rise, fall, wrap} !== '0) begin n_fail++; $display("FAIL rst_mid_pulses got %h/%h/%b want 0", rise, fall, wrap); end
    cyc(1, 0, 0, 0, '0, 1, 0);
    idle();
    n_tests++; if (chan_valid !== 1'b0) begin n_fail++; $display("FAIL rst_drops_read got valid %b want 0", chan_valid); end
  endtask

  task automatic test_random();
    logic [S-1:0] lv;
    for (int i = 0; i < 400; i++) begin
      lv = ($urandom_range(0, 1) == 0) ? ({S{1'b1}} - S'($urandom_range(0, 3))) : {1'($urandom), 32'($urandom)};
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 9) == 0, lv, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
      n_tests++;
      if (stage !== m_cnt || rise !== e_rise || fall !== e_fall || wrap !== e_wrap) begin
        n_fail++; $display("FAIL rand%0d_scaler got %h/%h/%h/%b want %h/%h/%h/%b", i, stage, rise, fall, wrap, m_cnt, e_rise, e_fall, e_wrap);
      end
      n_tests++;
      if (chan !== m_chan || chan_valid !== e_cv) begin
        n_fail++; $display("FAIL rand%0d_chan got %h/%b want %h/%b", i, chan, chan_valid, m_chan, e_cv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ticks();
    test_wrap();
    test_adv_merge();
    test_read();
    test_coherent();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scaler_chain_param.md
Name: scaler_chain_param

Overview:
- Parametrised successor to the fixed 33-stage timer scaler: a binary ripple-equivalent scaler of STAGES bits, advanced by a single-cycle tick.
- Emits per-stage level outputs (FSnn equivalents) and one-cycle rise/fall pulses per stage (FnnA/FnnB equivalents), plus a wrap pulse.
- Exposes two channel read windows (low/high, CHAT/CHBT equivalents), with optional coherent snapshot between them.
- Sits in the timer module, feeding time counters, the channel bus and downstream timing logic.

Parameters:
STAGES, 33, scaler width; stage n (1-based) = cnt[n-1]
CHW, 14, channel word width
LO_BASE, 5, 1-based stage mapped to low-window bit 1; high window starts at LO_BASE+CHW; LO_BASE+2*CHW-1 <= STAGES is required (elaboration error otherwise)

Ports:
CLOCK  in  1  system clock
rst  in  1  synchronous active-high reset
tick  in  1  one-cycle advance strobe (FS01 half-period equivalent)
test_adv  in  1  test advance (CGA1-style), advances every cycle while high
ld  in  1  load strobe
ld_val  in  STAGES  load value
rd_lo  in  1  read low window strobe
rd_hi  in  1  read high window strobe
stage  out  STAGES  registered scaler value
rise  out  STAGES  one-cycle pulse per stage bit 0->1
fall  out  STAGES  one-cycle pulse per stage bit 1->0
wrap  out  1  one-cycle pulse on all-ones -> zero
chan  out  CHW  channel read data
chan_valid  out  1  one-cycle qualifier for chan

Behaviour:
- Reset: stage, rise, fall, wrap, chan, chan_valid, and the snapshot register and its valid flag all 0. Reset takes priority over everything. Reset mid-read drops the read: no chan_valid.
- Advance: adv = tick | test_adv. Simultaneous tick and test_adv give a single +1.
- Increment is modulo 2^STAGES. All-ones + 1 = 0 and asserts wrap.
- Priority: rst > ld > adv.
  - On ld, stage <= ld_val.
  - rise, fall and wrap are all 0 in a load cycle, regardless of adv.
- Pulse timing:
  - rise[i] = new[i] & ~old[i]; fall[i] = ~new[i] & old[i]; all registered.
  - Pulses appear in the same cycle the new stage value is visible: one cycle after the adv sample.
  - Each pulse is exactly 1 cycle. All pulses are 0 in cycles without adv.
- Read, latency 1:
  - On an edge sampling rd_lo: chan <= stage[LO_BASE-1 +: CHW], using the pre-update value at that edge, and chan_valid <= 1.
  - rd_hi behaves the same using stage[LO_BASE+CHW-1 +: CHW].
  - chan holds its last value when idle; chan_valid is 1 cycle only.
- Simultaneous rd_lo and rd_hi: rd_lo is served and rd_hi is ignored (no queued read).
- A read concurrent with adv or ld returns the pre-update value.

Optional Feature:
- Macro: SCALER_SNAPSHOT_EN.
- With the macro defined:
  - rd_lo also captures the pre-update high window into snap and sets snap_v.
  - rd_hi returns snap when snap_v is 1, then clears snap_v. When snap_v is 0 it returns the live high window.
  - ld clears snap_v.
  - A second rd_lo overwrites snap.
  - Result: a lo-then-hi read pair is coherent across a carry.
- Without the macro: no snap register; rd_hi always returns the live high window.

Test Plan:
- Reset, then 5 single ticks spaced 3 cycles apart:
  - Final stage = 5.
  - rise[0] pulses after ticks 1, 3, 5; fall[0] after ticks 2, 4.
  - rise[1] after tick 2; rise[2] after tick 4.
  - wrap never asserts.
- ld_val = 2^33-2, then 2 ticks:
  - After the 2nd tick, stage = 0, wrap = 1 for 1 cycle, fall = all-ones for 1 cycle, rise = 0.
- tick and test_adv both high for 1 cycle from stage 0 -> stage = 1. test_adv held high 8 cycles -> stage = 8.
- ld_val = 0x0_0003_FFF0 (stage bits 5..18 all 1):
  - rd_lo -> next cycle chan = 0x3FFF, chan_valid = 1 for 1 cycle.
  - rd_lo and rd_hi in the same cycle -> a single chan_valid with the low data.
- ld_val with low window all-ones and high window = 0x0005:
  - rd_lo together with tick, then rd_hi 2 cycles later.
  - Low read returns 0x3FFF (pre-increment).
  - High read returns 0x0005 with SCALER_SNAPSHOT_EN, 0x0006 without.
- rst asserted the cycle after rd_hi while ticking -> chan = 0, chan_valid = 0, stage = 0, no pulses that cycle.
